// File: rtl/alu_seq_control.sv
// Sequencer driving ALU/shifter controls; shifts run one step per cycle.
// Define ALU_SEQ_CONTROL_ERR_EN to add the ERR output for reserved opcode 111.
module alu_seq_control #(
   parameter int SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               cisel,
   output logic               bsel,
   output logic [1:0]         osel,
   output logic               shift_la,
   output logic               shift_lr,
   output logic               logical_op,
   output logic               alu_en,
   output logic               busy,
`ifdef ALU_SEQ_CONTROL_ERR_EN
   output logic               err,
`endif
   output logic               done
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state, state_n;
   logic [2:0]         op_q;
   logic [SHAMT_W-1:0] cnt;
   logic [6:0]         ctrl_q;
   logic               accept;
   logic               rsv;

   function automatic logic is_shift(input logic [2:0] o);
      return (o == 3'b010) || (o == 3'b011) || (o == 3'b100);
   endfunction

   // {cisel, bsel, osel, shift_la, shift_lr, logical_op}
   function automatic logic [6:0] decode(input logic [2:0] o);
      logic [1:0] osel_v;
      unique case (1'b1)
         is_shift(o):                     osel_v = 2'b01;
         (o == 3'b101) || (o == 3'b110): osel_v = 2'b10;
         default:                         osel_v = 2'b00;
      endcase
      return {o == 3'b001, o == 3'b001, osel_v,
              o == 3'b010, o != 3'b100, o == 3'b101};
   endfunction

`ifdef ALU_SEQ_CONTROL_ERR_EN
   assign rsv = (op == 3'b111);
   assign err = (state == DONE) && (op_q == 3'b111);
`else
   assign rsv = 1'b0;
`endif

   assign accept = (state == IDLE) && in_valid;

   assign {cisel, bsel, osel, shift_la, shift_lr, logical_op} = ctrl_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      alu_en   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (rsv || (is_shift(op) && shamt == '0))
                  state_n = DONE;
               else
                  state_n = EXEC;
            end
         end
         EXEC: begin
            alu_en = 1'b1;
            busy   = 1'b1;
            // Non-shift ops take a single step regardless of the count.
            if (!is_shift(op_q) || cnt == SHAMT_W'(1))
               state_n = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= '0;
         cnt    <= '0;
         ctrl_q <= '0;
      end else if (accept) begin
         op_q   <= op;
         cnt    <= shamt;
         ctrl_q <= rsv ? 7'd0 : decode(op);
      end else if (state == EXEC) begin
         cnt <= cnt - SHAMT_W'(1);
      end else if (state == DONE) begin
         ctrl_q <= '0;
      end
   end

endmodule

// File: tb/tb_alu_seq_control.sv
// Directed bench for alu_seq_control with a per-instruction scoreboard.
// Build with ALU_SEQ_CONTROL_ERR_EN to cover the ERR output.
module tb_alu_seq_control;

   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic [SW-1:0] shamt;
   logic          cisel, bsel;
   logic [1:0]    osel;
   logic          shift_la, shift_lr, logical_op;
   logic          alu_en, busy, done;
   logic          err_v;
`ifdef ALU_SEQ_CONTROL_ERR_EN
   logic          err;
   assign err_v = err;
`else
   assign err_v = 1'b0;
`endif

   alu_seq_control #(.SHAMT_W(SW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .shamt      (shamt),
      .cisel      (cisel),
      .bsel       (bsel),
      .osel       (osel),
      .shift_la   (shift_la),
      .shift_lr   (shift_lr),
      .logical_op (logical_op),
      .alu_en     (alu_en),
      .busy       (busy),
`ifdef ALU_SEQ_CONTROL_ERR_EN
      .err        (err),
`endif
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         lat;
      int         steps;
      logic [6:0] ctrl;
      logic       err;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   passed = 0;

   logic [6:0] ctrl_obs;
   assign ctrl_obs = {cisel, bsel, osel, shift_la, shift_lr, logical_op};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [SW-1:0] s);
      exp_t e;
      bit   sh;
      bit   rsv;
      logic [1:0] os;
      sh = (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
`ifdef ALU_SEQ_CONTROL_ERR_EN
      rsv = (o == 3'd7);
`else
      rsv = 1'b0;
`endif
      if (sh)                         os = 2'b01;
      else if (o == 3'd5 || o == 3'd6) os = 2'b10;
      else                            os = 2'b00;
      e.steps = rsv ? 0 : (sh ? int'(s) : 1);
      e.lat   = (e.steps == 0) ? 1 : e.steps + 1;
      e.ctrl  = rsv ? 7'd0 : {o == 3'd1, o == 3'd1, os, o == 3'd2,
                              o != 3'd4, o == 3'd5};
      e.err   = rsv;
      return e;
   endfunction

   task automatic run(input string nm, input logic [2:0] o,
                      input logic [SW-1:0] s, input bit hold);
      exp_t e;
      int   cyc;
      int   steps;
      bit   got;
      logic err_at_done;
      sbq.push_back(model(o, s));
      @(negedge clk);
      in_valid = 1'b1;
      op       = o;
      shamt    = s;
      chk({nm, "_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
      e = sbq[0];
      cyc = 0;
      steps = 0;
      got = 0;
      err_at_done = 1'b0;
      while (!got && cyc < 40) begin
         cyc++;
         if (alu_en) steps++;
         chk({nm, "_ctrl"}, ctrl_obs, e.ctrl);
         chk({nm, "_busy_rdy"}, {busy, in_ready}, 2'b10);
         if (done) begin
            got = 1;
            err_at_done = err_v;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      e = sbq.pop_front();
      chk({nm, "_done_seen"}, got, 1);
      chk({nm, "_latency"}, cyc, e.lat);
      chk({nm, "_steps"}, steps, e.steps);
      chk({nm, "_err"}, err_at_done, e.err);
      @(posedge clk);
      #1;
      chk({nm, "_idle"}, {in_ready, busy, done, alu_en, ctrl_obs},
          {4'b1000, 7'd0});
   endtask

   initial begin
      int seen_done;
      int seen_en;
      reset    = 1'b1;
      in_valid = 1'b0;
      op       = '0;
      shamt    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {in_ready, busy, done, alu_en, ctrl_obs, err_v},
          {4'b1000, 7'd0, 1'b0});
      reset = 1'b0;

      run("sub",    3'd1, 3'd0, 1'b0);
      run("add",    3'd0, 3'd5, 1'b0);
      run("sra5",   3'd4, 3'd5, 1'b0);
      run("sll0",   3'd2, 3'd0, 1'b0);
      run("sll7",   3'd2, 3'd7, 1'b0);
      run("srl3",   3'd3, 3'd3, 1'b0);
      run("srl1",   3'd3, 3'd1, 1'b0);
      run("logica", 3'd5, 3'd2, 1'b0);
      run("logicb", 3'd6, 3'd0, 1'b0);
      run("rsv",    3'd7, 3'd4, 1'b0);
      run("hold1",  3'd3, 3'd4, 1'b1);
      run("hold2",  3'd0, 3'd0, 1'b0);

      // Reset lands on the third step of a 6-step arithmetic shift.
      @(negedge clk);
      in_valid = 1'b1;
      op       = 3'd4;
      shamt    = 3'd6;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("rst_mid_step3", {alu_en, busy}, 2'b11);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_after", {in_ready, busy, done, alu_en, ctrl_obs},
          {4'b1000, 7'd0});
      reset = 1'b0;
      seen_done = 0;
      seen_en = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) seen_done++;
         if (alu_en) seen_en++;
      end
      chk("rst_mid_no_done", seen_done, 0);
      chk("rst_mid_no_en", seen_en, 0);

      run("post_rst", 3'd1, 3'd3, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_seq_control.md
ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 Parameter SHAMT_W, default 3; width of shift-amount field (max step count 2^SHAMT_W-1).
REQ-002 CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 IN_VALID  input  1  instruction present on OP/SHAMT.
REQ-005 IN_READY  output  1  block can accept an instruction.
REQ-006 OP  input  3  opcode: 000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA, 101 LOGIC-A, 110 LOGIC-B, 111 reserved.
REQ-007 SHAMT  input  SHAMT_W  shift step count, used only for 010/011/100.
REQ-008 CISEL, BSEL  output  1 each  carry-in select / B-invert select.
REQ-009 OSEL  output  2  result mux select: 00 adder, 01 shifter, 10 logic unit.
REQ-010 SHIFT_LA, SHIFT_LR, LOGICAL_OP  output  1 each  shifter logical/arith, shifter left/right, logic-unit function select.
REQ-011 ALU_EN  output  1  datapath write strobe; one ALU operation or one 1-bit shift step per high cycle.
REQ-012 BUSY  output  1  instruction in progress; DONE  output  1  single-cycle completion pulse.

Function
REQ-013 States SHALL be IDLE, EXEC, DONE; IN_READY SHALL be 1 only in IDLE.
REQ-014 Accept SHALL occur on an edge with IN_VALID=1 in IDLE; OP and SHAMT SHALL be captured into registers then; IN_VALID outside IDLE SHALL be ignored.
REQ-015 Decode from captured OP: CISEL=BSEL=1 only for SUB; OSEL=01 for 010/011/100, 10 for 101/110, else 00; SHIFT_LA=1 only for SLL; SHIFT_LR=0 only for SRA; LOGICAL_OP=1 only for LOGIC-A.
REQ-016 Decoded controls SHALL be registered, valid from the cycle after accept through the DONE cycle, and all 0 in IDLE.
REQ-017 Non-shift ops: IDLE -> EXEC for exactly 1 cycle with ALU_EN=1 -> DONE.
REQ-018 Shift ops with SHAMT=N>0: EXEC SHALL last N consecutive cycles with ALU_EN=1, tracked by a SHAMT_W-bit down-counter loaded with N at accept; exit when counter reaches 1.
REQ-019 Shift ops with SHAMT=0: IDLE -> DONE directly, ALU_EN never asserted.
REQ-020 SHAMT=2^SHAMT_W-1 SHALL yield exactly that many steps, no counter wrap.
REQ-021 DONE SHALL be high for exactly 1 cycle, then IDLE; BUSY=1 in EXEC and DONE.
REQ-022 Accept-to-DONE latency: 2 cycles non-shift, N+1 shift (N>0), 1 cycle for N=0; back-to-back accept possible the cycle after DONE.

Reset
REQ-023 RESET=1 at an edge SHALL force IDLE, clear counter and captured OP, and drive all outputs 0 except IN_READY=1, regardless of state.
REQ-024 Reset mid-EXEC SHALL abort with no further ALU_EN and no DONE pulse.

Configuration
REQ-025 Macro ALU_SEQ_CONTROL_ERR_EN: when defined, output ERR (1 bit) SHALL pulse with DONE for reserved OP 111, which goes IDLE -> DONE with ALU_EN never asserted and controls 0.
REQ-026 Without ALU_SEQ_CONTROL_ERR_EN: no ERR port; OP 111 SHALL execute as ADD.

Verification
REQ-027 Reset then IDLE, OP=001 accepted -> next cycle CISEL=BSEL=1, OSEL=00, ALU_EN=1 for 1 cycle; DONE 2 cycles after accept.
REQ-028 OP=100, SHAMT=5 -> OSEL=01, SHIFT_LR=0, ALU_EN high exactly 5 cycles, DONE on 6th cycle after accept.
REQ-029 OP=010, SHAMT=0 -> DONE 1 cycle after accept, ALU_EN never high; SHAMT=7 (SHAMT_W=3) -> 7 steps.
REQ-030 IN_VALID held high continuously during shift -> second instruction accepted only the cycle after DONE, IN_READY low throughout.
REQ-031 RESET asserted on 3rd step of SHAMT=6 shift -> next cycle IDLE, IN_READY=1, all controls 0, no DONE.
REQ-032 OP=111 with ERR_EN -> ERR=DONE=1 one cycle after accept, ALU_EN 0; without -> behaves as ADD.
